mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester. Each access runs IDLE -> ACCESS (LATENCY cycles) ->
// DONE (one-cycle ack). Fixed data priority by default; defining the macro
// MEM_ARB_RR_EN switches contention handling to round-robin.
module mem_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [1:0]  dm_width_i,
    output logic        dm_ack_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [1:0]  mem_width_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        last_cnt;
    logic        any_req;
    logic        grant_dm;
    logic        lat_sel_dm;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_width;

    assign any_req  = if_req_i | dm_req_i;
    assign last_cnt = (cnt == 4'(LATENCY - 1));

`ifdef MEM_ARB_RR_EN
    logic last_grant_dm;

    // Round-robin winner: on contention the port that did not win last time goes
    always_comb begin
        grant_dm = dm_req_i;
        if (if_req_i && dm_req_i) begin
            grant_dm = ~last_grant_dm;
        end
    end

    // Remember who was granted; reset to fetch so data wins the first contention
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_dm <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_grant_dm <= grant_dm;
        end
    end
`else
    assign grant_dm = dm_req_i;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and memory/ack outputs; mem command is zero outside ACCESS
    always_comb begin
        state_nxt   = state;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        mem_width_o = 2'b00;
        if_ack_o    = 1'b0;
        dm_ack_o    = 1'b0;
        busy_o      = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en_o    = (cnt == 4'd0);
                mem_we_o    = (cnt == 4'd0) && lat_we;
                mem_addr_o  = lat_addr;
                mem_wdata_o = lat_wdata;
                mem_width_o = lat_width;
                if (last_cnt) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if_ack_o  = ~lat_sel_dm;
                dm_ack_o  = lat_sel_dm;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winning command, count access cycles, capture read data on the last one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt        <= 4'd0;
            lat_sel_dm <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_width  <= 2'b00;
            if_rdata_o <= 32'h0;
            dm_rdata_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (any_req) begin
                        lat_sel_dm <= grant_dm;
                        lat_we     <= grant_dm ? dm_we_i : 1'b0;
                        lat_addr   <= grant_dm ? dm_addr_i : if_addr_i;
                        lat_wdata  <= grant_dm ? dm_wdata_i : 32'h0;
                        lat_width  <= grant_dm ? dm_width_i : 2'b10;
                    end
                end
                ACCESS: begin
                    if (last_cnt) begin
                        cnt <= 4'd0;
                        if (!lat_we) begin
                            if (lat_sel_dm) begin
                                dm_rdata_o <= mem_rdata_i;
                            end else begin
                                if_rdata_o <= mem_rdata_i;
                            end
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter. A scoreboard
// queue holds the expected transaction for each request; it is popped when an
// ack appears. A second LATENCY=1 instance checks back-to-back fetch timing.
module tb_mem_arbiter;

    localparam int LAT = 2;

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic [1:0]  dm_width = 2'b00;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_width;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    logic        if_req1 = 1'b0;
    logic [31:0] if_addr1 = 32'h0;
    logic        if_ack1;
    logic [31:0] if_rdata1;
    logic        dm_ack1;
    logic [31:0] dm_rdata1;
    logic        mem_en1;
    logic        mem_we1;
    logic [31:0] mem_addr1;
    logic [31:0] mem_wdata1;
    logic [1:0]  mem_width1;
    logic [31:0] mem_rdata1 = 32'h0;
    logic        busy1;

    txn_t        sb[$];
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_dm_rdata = 32'h0;
    int          errors = 0;
    int          checks = 0;

    mem_arbiter #(.LATENCY(LAT)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_width_i(dm_width), .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_width_o(mem_width), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    mem_arbiter #(.LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req1), .if_addr_i(if_addr1), .if_ack_o(if_ack1), .if_rdata_o(if_rdata1),
        .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0),
        .dm_width_i(2'b00), .dm_ack_o(dm_ack1), .dm_rdata_o(dm_rdata1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
        .mem_width_o(mem_width1), .mem_rdata_i(mem_rdata1), .busy_o(busy1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case a wait is never satisfied
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a single request on one port and record its expected outcome
    task automatic applyStimulus(input bit is_dm, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] width,
                                 input logic [31:0] rdata);
        txn_t t;
        t.is_dm = is_dm;
        t.we    = is_dm ? we : 1'b0;
        t.addr  = addr;
        t.wdata = is_dm ? wdata : 32'h0;
        t.width = is_dm ? width : 2'b10;
        t.rdata = rdata;
        sb.push_back(t);
        mem_rdata = rdata;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_width = width;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
    endtask

    task automatic pushExpected(input bit is_dm, input logic [31:0] addr,
                                input logic [1:0] width, input logic [31:0] rdata);
        txn_t t;
        t.is_dm = is_dm; t.we = 1'b0; t.addr = addr; t.wdata = 32'h0;
        t.width = width; t.rdata = rdata;
        sb.push_back(t);
    endtask

    // Step until an ack appears; check the mem command, ack timing and scoreboard entry
    task automatic awaitAck(input string tag, input int exp_ack);
        int  cyc = 0;
        int  en_count = 0;
        bit  got = 0;
        txn_t t;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (mem_en === 1'b1) begin
                en_count++;
                checkOutput({tag, "_en_cycle"}, cyc, exp_ack - LAT);
                if (sb.size() > 0) begin
                    checkOutput({tag, "_addr"}, mem_addr, sb[0].addr);
                    checkOutput({tag, "_we"}, {31'h0, mem_we}, {31'h0, sb[0].we});
                    checkOutput({tag, "_wdata"}, mem_wdata, sb[0].wdata);
                    checkOutput({tag, "_width"}, {30'h0, mem_width}, {30'h0, sb[0].width});
                end
            end else begin
                checkOutput({tag, "_we_idle"}, {31'h0, mem_we}, 32'h0);
            end
            checkOutput({tag, "_one_ack"}, {31'h0, if_ack & dm_ack}, 32'h0);
            if (if_ack === 1'b1 || dm_ack === 1'b1) begin
                got = 1;
                checkOutput({tag, "_ack_cycle"}, cyc, exp_ack);
                checkOutput({tag, "_en_count"}, en_count, 1);
                checkOutput({tag, "_mem_idle"}, mem_addr | mem_wdata, 32'h0);
                if (sb.size() == 0) begin
                    checkOutput({tag, "_unexpected_ack"}, 32'h1, 32'h0);
                end else begin
                    t = sb.pop_front();
                    checkOutput({tag, "_port"}, {31'h0, dm_ack}, {31'h0, t.is_dm});
                    if (!t.we) begin
                        if (t.is_dm) exp_dm_rdata = t.rdata;
                        else exp_if_rdata = t.rdata;
                    end
                    checkOutput({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
                    checkOutput({tag, "_dm_rdata"}, dm_rdata, exp_dm_rdata);
                end
            end
        end
        if (!got) begin
            checkOutput({tag, "_ack_timeout"}, 32'h0, 32'h1);
        end
    endtask

    // Directed sequence
    initial begin
        bit exp_busy1[6] = '{1, 1, 0, 1, 1, 0};
        bit exp_ack1[6]  = '{0, 1, 0, 0, 1, 0};

        $display("[TB] start");
        tick();
        tick();
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_mem_en", {31'h0, mem_en}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
        checkOutput("rst_if_rdata", if_rdata, 32'h0);
        checkOutput("rst_dm_rdata", dm_rdata, 32'h0);
        rst = 1'b0;
        tick();

        applyStimulus(0, 0, 32'h40, 32'h0, 2'b10, 32'hDEADBEEF);
        awaitAck("fetch40", LAT + 1);
        if_req = 1'b0;
        tick();

        applyStimulus(1, 0, 32'h200, 32'h0, 2'b10, 32'h55AA1234);
        awaitAck("dread200", LAT + 1);
        dm_req = 1'b0;
        tick();

        applyStimulus(1, 1, 32'h100, 32'h12345678, 2'b10, 32'hCAFEF00D);
        awaitAck("dwrite100", LAT + 1);
        dm_req = 1'b0;
        tick();

        applyStimulus(1, 0, 32'h203, 32'h0, 2'b00, 32'h000000AB);
        awaitAck("dbyte203", LAT + 1);
        dm_req = 1'b0;
        tick();

        applyStimulus(0, 0, 32'h44, 32'h0, 2'b10, 32'h13572468);
        tick();
        checkOutput("abort_en", {31'h0, mem_en}, 32'h1);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("abort_mem", mem_addr | {31'h0, mem_en}, 32'h0);
        checkOutput("abort_if_rdata", if_rdata, 32'h0);
        checkOutput("abort_dm_rdata", dm_rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_no_ack", {30'h0, if_ack, dm_ack}, 32'h0);
        end
        sb.delete();
        exp_if_rdata = 32'h0;
        exp_dm_rdata = 32'h0;
        rst = 1'b0;
        applyStimulus(0, 0, 32'h44, 32'h0, 2'b10, 32'h77778888);
        awaitAck("regrant44", LAT + 1);
        if_req = 1'b0;
        tick();

        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_width = 2'b01;
        mem_rdata = 32'h11112222;
        pushExpected(1, 32'h300, 2'b01, 32'h11112222);
`ifdef MEM_ARB_RR_EN
        pushExpected(0, 32'h80, 2'b10, 32'h11112222);
`else
        pushExpected(1, 32'h300, 2'b01, 32'h11112222);
`endif
        pushExpected(1, 32'h300, 2'b01, 32'h11112222);
        awaitAck("contend1", LAT + 1);
        awaitAck("contend2", LAT + 2);
        awaitAck("contend3", LAT + 2);
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        checkOutput("sb_empty", sb.size(), 0);

        if_req1 = 1'b1; if_addr1 = 32'h0; mem_rdata1 = 32'hA0A0A0A0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checkOutput($sformatf("lat1_busy_c%0d", c), {31'h0, busy1}, {31'h0, exp_busy1[c-1]});
            checkOutput($sformatf("lat1_ack_c%0d", c), {31'h0, if_ack1}, {31'h0, exp_ack1[c-1]});
            if (c == 2) if_addr1 = 32'h4;
            if (c == 3) begin
                checkOutput("lat1_rdata0", if_rdata1, 32'hA0A0A0A0);
                mem_rdata1 = 32'hB0B0B0B0;
            end
            if (c == 4) checkOutput("lat1_addr4", mem_addr1, 32'h4);
            if (c == 5) if_req1 = 1'b0;
            if (c == 6) checkOutput("lat1_rdata4", if_rdata1, 32'hB0B0B0B0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
